// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: ALU and M-extension op codes, MDU FSM states.
package ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  localparam logic [4:0] ITER_LAST = 5'd31;

  function automatic logic op_is_div(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input mdu_op_e op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic op_b_signed(input mdu_op_e op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Radix-2 multiply/divide datapath on unsigned magnitudes; one step per step_i.
// acc_q holds the 64-bit product, or {33-bit partial remainder, quotient/dividend}.
module mdu_iter
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        is_div_i,
  input  logic [31:0] mag_a_i,
  input  logic [31:0] mag_b_i,
  output logic [63:0] prod_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  logic [64:0] acc_q, acc_d;
  logic [31:0] opd_q, opd_d;
  logic        is_div_q, is_div_d;

  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;

  always_comb begin
    acc_d     = acc_q;
    opd_d     = opd_q;
    is_div_d  = is_div_q;
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opd_q} : 33'd0);
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opd_q};

    if (load_i) begin
      is_div_d = is_div_i;
      // Divide keeps the dividend in the low half and the divisor in opd;
      // multiply keeps the multiplier in the low half and the multiplicand in opd.
      acc_d    = {33'd0, is_div_i ? mag_a_i : mag_b_i};
      opd_d    = is_div_i ? mag_b_i : mag_a_i;
    end else if (step_i) begin
      if (is_div_q) begin
        if (!div_diff[32]) acc_d = {div_diff, acc_q[30:0], 1'b1};
        else               acc_d = {div_shift, acc_q[30:0], 1'b0};
      end else begin
        acc_d = {1'b0, mul_sum, acc_q[31:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      opd_q    <= '0;
      is_div_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      is_div_q <= is_div_d;
    end
  end

  assign prod_o = acc_q[63:0];
  assign quot_o = acc_q[31:0];
  assign rem_o  = acc_q[63:32];

endmodule

// File: rtl/ex_mdu_ctrl.sv
// EX-stage M-extension sequencer: FSM, step counter, special cases, sign fix, stall handshake.
// Normal ops take 32 ITER cycles plus FIX; divide-by-zero and signed overflow retire straight from IDLE.
module ex_mdu_ctrl
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mdu_start_i,
  input  logic [2:0]  mdu_op_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [4:0]  rd_add_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_add_o
);

  mdu_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  mdu_op_e     op_q;
  logic        neg_q;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_q;

  mdu_op_e     op_in;
  logic        a_neg, b_neg, neg_in;
  logic [31:0] mag_a, mag_b;
  logic        div_zero, div_ovf, special;
  logic [31:0] special_res;
  logic        capture, load, step;

  logic [63:0] prod;
  logic [31:0] quot, rem;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix, fix_res;

  assign op_in  = mdu_op_e'(mdu_op_i);
  assign a_neg  = op_a_signed(op_in) & op_a_i[31];
  assign b_neg  = op_b_signed(op_in) & op_b_i[31];
  assign mag_a  = a_neg ? (32'd0 - op_a_i) : op_a_i;
  assign mag_b  = b_neg ? (32'd0 - op_b_i) : op_b_i;
  // Remainders follow the dividend's sign; products and quotients the XOR of both.
  assign neg_in = (op_in == MDU_REM) ? a_neg : (a_neg ^ b_neg);

  assign div_zero = op_is_div(op_in) && (op_b_i == 32'd0);
  assign div_ovf  = ((op_in == MDU_DIV) || (op_in == MDU_REM)) &&
                    (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_res = 32'd0;
    if (div_zero)     special_res = op_in[1] ? op_a_i : 32'hFFFF_FFFF;
    else if (div_ovf) special_res = op_in[1] ? 32'd0 : 32'h8000_0000;
  end

  assign capture = (state_q == IDLE) && mdu_start_i && !flush_i;

  mdu_iter u_iter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .step_i   (step),
    .is_div_i (op_is_div(op_in)),
    .mag_a_i  (mag_a),
    .mag_b_i  (mag_b),
    .prod_o   (prod),
    .quot_o   (quot),
    .rem_o    (rem)
  );

  assign prod_fix = neg_q ? (64'd0 - prod) : prod;
  assign quot_fix = neg_q ? (32'd0 - quot) : quot;
  assign rem_fix  = neg_q ? (32'd0 - rem)  : rem;

  always_comb begin
    fix_res = 32'd0;
    case (op_q)
      MDU_MUL:                         fix_res = prod_fix[31:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = prod_fix[63:32];
      MDU_DIV, MDU_DIVU:               fix_res = quot_fix;
      MDU_REM, MDU_REMU:               fix_res = rem_fix;
      default:                         fix_res = 32'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          if (special) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            load    = 1'b1;
            cnt_d   = 5'd0;
            state_d = ITER;
          end
        end
      end
      ITER: begin
        step = 1'b1;
        if (cnt_q == ITER_LAST) state_d = FIX;
        else                    cnt_d   = cnt_q + 5'd1;
      end
      FIX: begin
        result_d = fix_res;
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A flushed op must leave no trace in the result or the datapath.
    if (flush_i) begin
      state_d  = IDLE;
      cnt_d    = 5'd0;
      result_d = result_q;
      load     = 1'b0;
      step     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
      rd_q     <= 5'd0;
      op_q     <= MDU_MUL;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      if (capture) begin
        op_q  <= op_in;
        neg_q <= neg_in;
        rd_q  <= rd_add_i;
      end
    end
  end

  // DONE does not stall, so the pipeline moves on the same edge that retires the result.
  assign stall_o  = capture || (state_q == ITER) || (state_q == FIX);
  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE) && !flush_i;
  assign result_o = result_q;
  assign rd_add_o = rd_q;

endmodule

// File: tb/tb_ex_mdu_ctrl.sv
// Directed bench for ex_mdu_ctrl: latency, stall window, results, flush and reset behaviour.
module tb_ex_mdu_ctrl;

  logic        clk;
  logic        rst;
  logic        mdu_start_i;
  logic [2:0]  mdu_op_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic [4:0]  rd_add_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_add_o;

  int checks = 0;
  int errors = 0;

  localparam int EDGE_LIMIT = 60;
  // Edges after the capture edge until done_o is visible: 32 ITER + 1 FIX, or none for special cases.
  localparam int LAT_NORMAL  = 33;
  localparam int LAT_SPECIAL = 0;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3,
                         OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  ex_mdu_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .mdu_start_i (mdu_start_i),
    .mdu_op_i    (mdu_op_i),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .rd_add_i    (rd_add_i),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o),
    .rd_add_o    (rd_add_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input int exp_edges,
                       input logic [31:0] exp_res, input bit hold_in_done);
    int edges;
    int gaps;
    mdu_start_i = 1'b1;
    mdu_op_i    = op;
    op_a_i      = a;
    op_b_i      = b;
    rd_add_i    = rd;
    #1;
    chk({tag, "_stall_req"}, {31'd0, stall_o}, 32'd1);
    tick();
    mdu_start_i = 1'b0;
    op_a_i      = $urandom;
    op_b_i      = $urandom;
    rd_add_i    = ~rd;
    edges = 0;
    gaps  = 0;
    while (done_o !== 1'b1 && edges < EDGE_LIMIT) begin
      if (stall_o !== 1'b1 || busy_o !== 1'b1) gaps++;
      tick();
      edges++;
    end
    chk({tag, "_latency"}, 32'(edges), 32'(exp_edges));
    chk({tag, "_result"}, result_o, exp_res);
    chk({tag, "_rd"}, {27'd0, rd_add_o}, {27'd0, rd});
    chk({tag, "_stall_done"}, {31'd0, stall_o}, 32'd0);
    chk({tag, "_busy_done"}, {31'd0, busy_o}, 32'd1);
    chk({tag, "_stall_gaps"}, 32'(gaps), 32'd0);
    if (hold_in_done) begin
      mdu_start_i = 1'b1;
      mdu_op_i    = op;
      op_a_i      = a;
      op_b_i      = b;
      #1;
      chk({tag, "_stall_hold"}, {31'd0, stall_o}, 32'd0);
    end
    tick();
    chk({tag, "_done_1cyc"}, {31'd0, done_o}, 32'd0);
    chk({tag, "_idle_after"}, {31'd0, busy_o}, 32'd0);
    mdu_start_i = 1'b0;
    #1;
  endtask

  initial begin
    int dones;
    rst = 1'b1;
    mdu_start_i = 1'b1;
    mdu_op_i = OP_MUL;
    op_a_i = 32'd1;
    op_b_i = 32'd1;
    rd_add_i = 5'd3;
    flush_i = 1'b0;
    tick();
    tick();
    // Reset wins over a pending start.
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", {27'd0, rd_add_o}, 32'd0);
    rst = 1'b0;
    mdu_start_i = 1'b0;
    #1;
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    tick();

    do_op("mul_neg",   OP_MUL,    32'd7,         32'hFFFF_FFFD, 5'd5,  LAT_NORMAL,  32'hFFFF_FFEB, 1'b0);
    do_op("mulhu_max", OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  LAT_NORMAL,  32'hFFFF_FFFE, 1'b0);
    do_op("mulh_m1",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  LAT_NORMAL,  32'h0000_0000, 1'b0);
    do_op("mulhsu",    OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd8,  LAT_NORMAL,  32'hFFFF_FFFF, 1'b0);
    do_op("div_zero",  OP_DIV,    32'd100,       32'd0,         5'd10, LAT_SPECIAL, 32'hFFFF_FFFF, 1'b0);
    do_op("rem_zero",  OP_REM,    32'd100,       32'd0,         5'd11, LAT_SPECIAL, 32'd100,       1'b0);
    do_op("div_ovf",   OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, LAT_SPECIAL, 32'h8000_0000, 1'b0);
    do_op("rem_ovf",   OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, LAT_SPECIAL, 32'd0,         1'b0);
    do_op("rem_neg",   OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd14, LAT_NORMAL,  32'hFFFF_FFFF, 1'b0);
    do_op("divu_big",  OP_DIVU,   32'hFFFF_FFF9, 32'd2,         5'd15, LAT_NORMAL,  32'h7FFF_FFFC, 1'b1);
    do_op("div_neg",   OP_DIV,    32'hFFFF_FFEC, 32'd6,         5'd16, LAT_NORMAL,  32'hFFFF_FFFD, 1'b0);
    do_op("remu",      OP_REMU,   32'd20,        32'd6,         5'd17, LAT_NORMAL,  32'd2,         1'b0);

    // Flush and start in the same cycle: flush wins.
    mdu_start_i = 1'b1;
    mdu_op_i = OP_MUL;
    op_a_i = 32'd9;
    op_b_i = 32'd9;
    rd_add_i = 5'd20;
    flush_i = 1'b1;
    #1;
    chk("flush_start_stall", {31'd0, stall_o}, 32'd0);
    tick();
    mdu_start_i = 1'b0;
    flush_i = 1'b0;
    #1;
    chk("flush_start_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_start_rd", {27'd0, rd_add_o}, 32'd17);

    // Flush a DIVU when its counter reaches 10.
    mdu_start_i = 1'b1;
    mdu_op_i = OP_DIVU;
    op_a_i = 32'd1000;
    op_b_i = 32'd7;
    rd_add_i = 5'd9;
    tick();
    mdu_start_i = 1'b0;
    repeat (10) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    chk("flush_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_stall", {31'd0, stall_o}, 32'd0);
    chk("flush_done", {31'd0, done_o}, 32'd0);
    chk("flush_result", result_o, 32'd2);
    chk("flush_rd", {27'd0, rd_add_o}, 32'd9);
    do_op("mul_b2b", OP_MUL, 32'd3, 32'd5, 5'd21, LAT_NORMAL, 32'd15, 1'b0);

    // Reset mid-ITER abandons the op.
    mdu_start_i = 1'b1;
    mdu_op_i = OP_DIVU;
    op_a_i = 32'd50;
    op_b_i = 32'd3;
    rd_add_i = 5'd22;
    tick();
    mdu_start_i = 1'b0;
    repeat (5) tick();
    chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_stall", {31'd0, stall_o}, 32'd0);
    chk("midrst_done", {31'd0, done_o}, 32'd0);
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_rd", {27'd0, rd_add_o}, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_o === 1'b1) dones++;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
